load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 22 ++
 rtl/load_store_unit_if.sv | 30 +++
 rtl/load_store_unit.sv | 103 ++++++++++
 tb/tb_load_store_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared types and defaults for the load/store unit
package load_store_unit_pkg;

  typedef logic [31:0] bus_type;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    RESP    = 2'd2
  } lsu_state_t;

  localparam int unsigned LSU_MEM_DEPTH = 32;
  localparam int unsigned LSU_MEM_AW    = 6;
  localparam int unsigned LSU_RD_W      = 5;
  localparam logic [7:0]  LSU_FAULT_MAX = 8'hFF;

  // Any set bit above the memory range makes the address illegal.
  function automatic logic addr_in_range(input bus_type addr, input int unsigned depth);
    return addr < bus_type'(depth);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response handshake between pipeline and load/store unit
interface load_store_unit_if;
  import load_store_unit_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic                req_is_store;
  bus_type             req_addr;
  bus_type             req_wdata;
  logic [LSU_RD_W-1:0] req_rd;

  logic                rsp_valid;
  logic                rsp_ready;
  bus_type             rsp_data;
  logic [LSU_RD_W-1:0] rsp_rd;
  logic                rsp_fault;

  // master: execute/writeback side of the pipeline
  modport master (
    output req_valid, req_is_store, req_addr, req_wdata, req_rd, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_rd, rsp_fault
  );

  // slave: the load/store unit itself
  modport slave (
    input  req_valid, req_is_store, req_addr, req_wdata, req_rd, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_rd, rsp_fault
  );

endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit in front of a registered-read data memory
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = LSU_MEM_DEPTH,
  parameter int unsigned MEM_AW    = LSU_MEM_AW
) (
  input  logic              clk,
  input  logic              reset,
  load_store_unit_if.slave  lsu,
  output logic [MEM_AW-1:0] mem_address,
  output bus_type           mem_input_data,
  output logic              mem_enable_read,
  output logic              mem_enable_write,
  input  bus_type           mem_read_data,
  output logic [7:0]        fault_count
);

  lsu_state_t          state;
  lsu_state_t          state_next;
  logic                accept;
  logic                addr_ok;
  bus_type             rsp_data_q;
  logic [LSU_RD_W-1:0] rsp_rd_q;
  logic                rsp_fault_q;

  assign addr_ok = addr_in_range(lsu.req_addr, MEM_DEPTH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Memory strobes are purely combinational from the accepting request, so the
  // address/data buses are forced to zero whenever no strobe is active.
  always_comb begin
    state_next       = state;
    accept           = 1'b0;
    lsu.req_ready    = 1'b0;
    mem_enable_read  = 1'b0;
    mem_enable_write = 1'b0;
    mem_address      = '0;
    mem_input_data   = '0;
    case (state)
      IDLE: begin
        lsu.req_ready = !reset;
        accept        = lsu.req_valid && !reset;
        if (accept) begin
          if (!addr_ok) begin
            state_next = RESP;
          end else if (lsu.req_is_store) begin
            mem_enable_write = 1'b1;
            mem_address      = lsu.req_addr[MEM_AW-1:0];
            mem_input_data   = lsu.req_wdata;
            state_next       = RESP;
          end else begin
            mem_enable_read = 1'b1;
            mem_address     = lsu.req_addr[MEM_AW-1:0];
            state_next      = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        state_next = RESP;
      end
      RESP: begin
        if (lsu.rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_data_q  <= '0;
      rsp_rd_q    <= '0;
      rsp_fault_q <= 1'b0;
      fault_count <= '0;
    end else if (accept) begin
      rsp_rd_q    <= lsu.req_rd;
      rsp_data_q  <= '0;
      rsp_fault_q <= !addr_ok;
      if (!addr_ok && fault_count != LSU_FAULT_MAX) begin
        fault_count <= fault_count + 8'd1;
      end
    end else if (state == CAPTURE) begin
      rsp_data_q <= mem_read_data;
    end
  end

  assign lsu.rsp_valid = (state == RESP);
  assign lsu.rsp_data  = rsp_data_q;
  assign lsu.rsp_rd    = rsp_rd_q;
  assign lsu.rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed scoreboard bench for load_store_unit with a behavioural data memory
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned AW    = 6;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        fault;
    int          lat;
  } exp_t;

  logic          clk;
  logic          reset;
  logic [AW-1:0] mem_address;
  bus_type       mem_input_data;
  logic          mem_enable_read;
  logic          mem_enable_write;
  bus_type       mem_read_data;
  logic [7:0]    fault_count;

  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] shadow [0:DEPTH-1];
  exp_t        sb [$];
  int          checks;
  int          errors;
  int          exp_faults;

  load_store_unit_if lsu ();

  load_store_unit #(.MEM_DEPTH(DEPTH), .MEM_AW(AW)) dut (
    .clk              (clk),
    .reset            (reset),
    .lsu              (lsu),
    .mem_address      (mem_address),
    .mem_input_data   (mem_input_data),
    .mem_enable_read  (mem_enable_read),
    .mem_enable_write (mem_enable_write),
    .mem_read_data    (mem_read_data),
    .fault_count      (fault_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_enable_write) mem[int'(mem_address)] <= mem_input_data;
    if (mem_enable_read)  mem_read_data <= mem[int'(mem_address)];
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic transact(input logic st, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] rd, input int hold);
    exp_t e;
    bit   ok;
    int   lat;
    ok      = (addr < 32'(DEPTH));
    e.rd    = rd;
    e.fault = !ok;
    e.data  = (ok && !st) ? shadow[addr[4:0]] : 32'h0;
    e.lat   = (ok && !st) ? 2 : 1;
    @(negedge clk);
    check("req_ready_idle", 32'(lsu.req_ready), 32'd1);
    lsu.req_valid    = 1'b1;
    lsu.req_is_store = st;
    lsu.req_addr     = addr;
    lsu.req_wdata    = wd;
    lsu.req_rd       = rd;
    #1;
    check("accept_we", 32'(mem_enable_write), 32'(ok && st));
    check("accept_re", 32'(mem_enable_read), 32'(ok && !st));
    check("accept_addr", 32'(mem_address), ok ? 32'(addr[AW-1:0]) : 32'h0);
    check("accept_wdata", mem_input_data, (ok && st) ? wd : 32'h0);
    sb.push_back(e);
    if (ok && st) shadow[addr[4:0]] = wd;
    if (!ok && exp_faults < 255) exp_faults++;
    @(posedge clk);
    @(negedge clk);
    lsu.req_valid = 1'b0;
    lat = 1;
    #1;
    check("post_accept_strobes", 32'({mem_enable_read, mem_enable_write}), 32'd0);
    check("post_accept_ready", 32'(lsu.req_ready), 32'd0);
    while (!lsu.rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("rsp_latency", 32'(lat), 32'(e.lat));
    e = sb.pop_front();
    if (!lsu.rsp_valid) return;
    check("rsp_data", lsu.rsp_data, e.data);
    check("rsp_rd", 32'(lsu.rsp_rd), 32'(e.rd));
    check("rsp_fault", 32'(lsu.rsp_fault), 32'(e.fault));
    check("fault_count", 32'(fault_count), 32'(exp_faults));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(lsu.rsp_valid), 32'd1);
      check("hold_data", lsu.rsp_data, e.data);
      check("hold_rd", 32'(lsu.rsp_rd), 32'(e.rd));
      check("hold_fault", 32'(lsu.rsp_fault), 32'(e.fault));
      check("hold_ready", 32'(lsu.req_ready), 32'd0);
    end
    lsu.rsp_ready = 1'b1;
    @(negedge clk);
    lsu.rsp_ready = 1'b0;
    #1;
    check("after_hs_valid", 32'(lsu.rsp_valid), 32'd0);
    check("after_hs_ready", 32'(lsu.req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    checks           = 0;
    errors           = 0;
    exp_faults       = 0;
    mem_read_data    = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem[i]    = 32'h0;
      shadow[i] = 32'h0;
    end
    reset            = 1'b1;
    lsu.req_valid    = 1'b0;
    lsu.req_is_store = 1'b0;
    lsu.req_addr     = '0;
    lsu.req_wdata    = '0;
    lsu.req_rd       = '0;
    lsu.rsp_ready    = 1'b0;

    #2;
    check("reset_ready", 32'(lsu.req_ready), 32'd0);
    check("reset_valid", 32'(lsu.rsp_valid), 32'd0);
    check("reset_fault", 32'(lsu.rsp_fault), 32'd0);
    check("reset_data", lsu.rsp_data, 32'h0);
    check("reset_rd", 32'(lsu.rsp_rd), 32'd0);
    check("reset_count", 32'(fault_count), 32'd0);
    check("reset_strobes", 32'({mem_enable_read, mem_enable_write}), 32'd0);
    lsu.req_valid = 1'b1;
    #1;
    check("reset_no_accept", 32'({lsu.req_ready, mem_enable_read}), 32'd0);
    lsu.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("ready_after_reset", 32'(lsu.req_ready), 32'd1);

    transact(1'b1, 32'd5, 32'hDEADBEEF, 5'd3, 0);
    transact(1'b0, 32'd5, 32'h0, 5'd7, 0);
    transact(1'b0, 32'd40, 32'h0, 5'd9, 0);
    transact(1'b1, 32'd31, 32'hA5A55A5A, 5'd1, 5);
    transact(1'b0, 32'd31, 32'h0, 5'd31, 5);
    transact(1'b1, 32'd32, 32'h12345678, 5'd2, 0);
    transact(1'b0, 32'h80000005, 32'h0, 5'd4, 0);
    transact(1'b1, 32'd0, 32'hCAFEF00D, 5'd0, 1);
    transact(1'b0, 32'd0, 32'h0, 5'd30, 0);
    for (int i = 0; i < 8; i++) begin
      a = 32'($urandom_range(0, 31));
      d = $urandom;
      transact(1'b1, a, d, 5'($urandom_range(0, 31)), 0);
      transact(1'b0, a, 32'h0, 5'($urandom_range(0, 31)), $urandom_range(0, 2));
    end

    // Reset while the load sits in CAPTURE: the response must vanish.
    @(negedge clk);
    lsu.req_valid    = 1'b1;
    lsu.req_is_store = 1'b0;
    lsu.req_addr     = 32'd5;
    lsu.req_rd       = 5'd12;
    @(posedge clk);
    @(negedge clk);
    lsu.req_valid = 1'b0;
    reset         = 1'b1;
    exp_faults    = 0;
    #1;
    check("mid_reset_valid", 32'(lsu.rsp_valid), 32'd0);
    check("mid_reset_ready", 32'(lsu.req_ready), 32'd0);
    check("mid_reset_count", 32'(fault_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_reset_release_ready", 32'(lsu.req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_reset_no_rsp", 32'(lsu.rsp_valid), 32'd0);
    end
    transact(1'b0, 32'd5, 32'h0, 5'd7, 0);

    for (int i = 0; i < 300; i++) begin
      a = (i % 2 == 0) ? 32'(32 + i) : (32'h1 << (5 + (i % 27)));
      transact(i[0], a, 32'(i), 5'(i), 0);
    end
    check("fault_saturated", 32'(fault_count), 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
